// File: rtl/strip_seq.sv
// strip_seq: sequences one LED-strip update (START, NUM_LEDS LED frames,
// END_FRAMES END frames) into a doled frame serialiser, fetching each
// pixel from an external buffer with a one-cycle read latency.
module strip_seq #(
    parameter int unsigned NUM_LEDS   = 60,
    parameter int unsigned END_FRAMES = 4,
    parameter int unsigned AW         = 10,
    parameter int unsigned HS_TIMEOUT = 255
) (
    input  logic          strip_clk,
    input  logic          strip_rst_n,
    input  logic          frame_go,
    output logic          frame_busy,
    output logic          frame_done,
    output logic          frame_err,
    output logic          pix_rd,
    output logic [AW-1:0] pix_addr,
    input  logic [23:0]   pix_data,
    output logic [1:0]    seq_type,
    output logic [7:0]    seq_blue,
    output logic [7:0]    seq_green,
    output logic [7:0]    seq_red,
    output logic          seq_start,
    input  logic          seq_busy
);

    localparam int unsigned HW = (HS_TIMEOUT > 1) ? $clog2(HS_TIMEOUT) : 1;
    localparam int unsigned EW = (END_FRAMES > 1) ? $clog2(END_FRAMES + 1) : 1;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ISSUE    = 3'd1;
    localparam logic [2:0] S_WAIT_LOW = 3'd2;
    localparam logic [2:0] S_FETCH    = 3'd3;
    localparam logic [2:0] S_LOAD     = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    localparam logic [1:0] T_START = 2'd0;
    localparam logic [1:0] T_LED   = 2'd1;
    localparam logic [1:0] T_END   = 2'd2;

    logic [2:0]    r_state;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic          r_rd;
    logic [AW-1:0] r_addr;
    logic [1:0]    r_type;
    logic [7:0]    r_red;
    logic [7:0]    r_green;
    logic [7:0]    r_blue;
    logic          r_start;
    logic [HW-1:0] r_hs_cnt;
    logic [AW-1:0] r_led_idx;
    logic [EW-1:0] r_end_cnt;

    logic [2:0]    w_state_nxt;
    logic          w_busy_nxt;
    logic          w_done_nxt;
    logic          w_err_nxt;
    logic          w_rd_nxt;
    logic [AW-1:0] w_addr_nxt;
    logic [1:0]    w_type_nxt;
    logic [7:0]    w_red_nxt;
    logic [7:0]    w_green_nxt;
    logic [7:0]    w_blue_nxt;
    logic          w_start_nxt;
    logic [HW-1:0] w_hs_cnt_nxt;
    logic [AW-1:0] w_led_idx_nxt;
    logic [EW-1:0] w_end_cnt_nxt;
    logic [EW-1:0] w_end_inc;
    logic [AW-1:0] w_led_inc;
    logic          w_last_led;
    logic          w_hs_expired;

    assign w_end_inc    = r_end_cnt + EW'(1);
    assign w_led_inc    = r_led_idx + AW'(1);
    assign w_last_led   = (r_led_idx == AW'(NUM_LEDS - 1));
    assign w_hs_expired = (r_hs_cnt == HW'(HS_TIMEOUT - 1));

    // Next-state and next-output logic; every register holds unless changed.
    always_comb begin
        w_state_nxt   = r_state;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_err_nxt     = r_err;
        w_rd_nxt      = 1'b0;
        w_addr_nxt    = r_addr;
        w_type_nxt    = r_type;
        w_red_nxt     = r_red;
        w_green_nxt   = r_green;
        w_blue_nxt    = r_blue;
        w_start_nxt   = r_start;
        w_hs_cnt_nxt  = r_hs_cnt;
        w_led_idx_nxt = r_led_idx;
        w_end_cnt_nxt = r_end_cnt;

        case (r_state)
            S_IDLE: begin
                if (frame_go) begin
                    w_busy_nxt   = 1'b1;
                    w_err_nxt    = 1'b0;
                    w_type_nxt   = T_START;
                    w_red_nxt    = 8'd0;
                    w_green_nxt  = 8'd0;
                    w_blue_nxt   = 8'd0;
                    w_start_nxt  = 1'b1;
                    w_hs_cnt_nxt = '0;
                    w_state_nxt  = S_ISSUE;
                end
            end

            S_ISSUE: begin
                if (seq_busy) begin
                    w_start_nxt = 1'b0;
                    w_state_nxt = S_WAIT_LOW;
                end else if (w_hs_expired) begin
                    // serialiser never acknowledged: abandon the update
                    w_err_nxt   = 1'b1;
                    w_start_nxt = 1'b0;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_hs_cnt_nxt = r_hs_cnt + HW'(1);
                end
            end

            S_WAIT_LOW: begin
                if (!seq_busy) begin
                    case (r_type)
                        T_START: begin
                            w_led_idx_nxt = '0;
                            w_addr_nxt    = '0;
                            w_rd_nxt      = 1'b1;
                            w_state_nxt   = S_FETCH;
                        end
                        T_LED: begin
                            if (w_last_led) begin
                                w_end_cnt_nxt = '0;
                                if (END_FRAMES == 0) begin
                                    w_done_nxt  = 1'b1;
                                    w_busy_nxt  = 1'b0;
                                    w_state_nxt = S_DONE;
                                end else begin
                                    w_type_nxt   = T_END;
                                    w_red_nxt    = 8'd0;
                                    w_green_nxt  = 8'd0;
                                    w_blue_nxt   = 8'd0;
                                    w_start_nxt  = 1'b1;
                                    w_hs_cnt_nxt = '0;
                                    w_state_nxt  = S_ISSUE;
                                end
                            end else begin
                                w_led_idx_nxt = w_led_inc;
                                w_addr_nxt    = w_led_inc;
                                w_rd_nxt      = 1'b1;
                                w_state_nxt   = S_FETCH;
                            end
                        end
                        default: begin
                            w_end_cnt_nxt = w_end_inc;
                            if (w_end_inc == EW'(END_FRAMES)) begin
                                w_done_nxt  = 1'b1;
                                w_busy_nxt  = 1'b0;
                                w_state_nxt = S_DONE;
                            end else begin
                                w_start_nxt  = 1'b1;
                                w_hs_cnt_nxt = '0;
                                w_state_nxt  = S_ISSUE;
                            end
                        end
                    endcase
                end
            end

            S_FETCH: begin
                w_state_nxt = S_LOAD;
            end

            S_LOAD: begin
                // pixel data returns the cycle after the read strobe
                w_red_nxt    = pix_data[23:16];
                w_green_nxt  = pix_data[15:8];
                w_blue_nxt   = pix_data[7:0];
                w_type_nxt   = T_LED;
                w_start_nxt  = 1'b1;
                w_hs_cnt_nxt = '0;
                w_state_nxt  = S_ISSUE;
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge strip_clk or negedge strip_rst_n) begin
        if (!strip_rst_n) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_rd      <= 1'b0;
            r_addr    <= '0;
            r_type    <= T_START;
            r_red     <= 8'd0;
            r_green   <= 8'd0;
            r_blue    <= 8'd0;
            r_start   <= 1'b0;
            r_hs_cnt  <= '0;
            r_led_idx <= '0;
            r_end_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
            r_rd      <= w_rd_nxt;
            r_addr    <= w_addr_nxt;
            r_type    <= w_type_nxt;
            r_red     <= w_red_nxt;
            r_green   <= w_green_nxt;
            r_blue    <= w_blue_nxt;
            r_start   <= w_start_nxt;
            r_hs_cnt  <= w_hs_cnt_nxt;
            r_led_idx <= w_led_idx_nxt;
            r_end_cnt <= w_end_cnt_nxt;
        end
    end

    assign frame_busy = r_busy;
    assign frame_done = r_done;
    assign frame_err  = r_err;
    assign pix_rd     = r_rd;
    assign pix_addr   = r_addr;
    assign seq_type   = r_type;
    assign seq_red    = r_red;
    assign seq_green  = r_green;
    assign seq_blue   = r_blue;
    assign seq_start  = r_start;

endmodule

// File: tb/tb_strip_seq.sv
// Bench for strip_seq: two instances (3 LEDs + 2 END frames, 1 LED + 0 END)
// each driving a doled model with a 20-cycle busy and a pixel buffer.
module tb_strip_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        go     [2];
    logic        dbusy  [2];
    logic        nobusy [2];
    logic [23:0] pdata  [2];
    logic        fbusy  [2];
    logic        fdone  [2];
    logic        ferr   [2];
    logic        prd    [2];
    logic [9:0]  paddr  [2];
    logic [1:0]  stype  [2];
    logic [7:0]  sr     [2];
    logic [7:0]  sg     [2];
    logic [7:0]  sb     [2];
    logic        sst    [2];

    logic [23:0] mem [4] = '{24'h112233, 24'h445566, 24'h778899, 24'hAABBCC};

    int chk_cnt  = 0;
    int pass_cnt = 0;

    strip_seq #(.NUM_LEDS(3), .END_FRAMES(2), .AW(10), .HS_TIMEOUT(255)) u_dut0 (
        .strip_clk(clk), .strip_rst_n(rst_n), .frame_go(go[0]),
        .frame_busy(fbusy[0]), .frame_done(fdone[0]), .frame_err(ferr[0]),
        .pix_rd(prd[0]), .pix_addr(paddr[0]), .pix_data(pdata[0]),
        .seq_type(stype[0]), .seq_blue(sb[0]), .seq_green(sg[0]), .seq_red(sr[0]),
        .seq_start(sst[0]), .seq_busy(dbusy[0]));

    strip_seq #(.NUM_LEDS(1), .END_FRAMES(0), .AW(10), .HS_TIMEOUT(255)) u_dut1 (
        .strip_clk(clk), .strip_rst_n(rst_n), .frame_go(go[1]),
        .frame_busy(fbusy[1]), .frame_done(fdone[1]), .frame_err(ferr[1]),
        .pix_rd(prd[1]), .pix_addr(paddr[1]), .pix_data(pdata[1]),
        .seq_type(stype[1]), .seq_blue(sb[1]), .seq_green(sg[1]), .seq_red(sr[1]),
        .seq_start(sst[1]), .seq_busy(dbusy[1]));

    task automatic check(input string nm, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic int n_leds(input int g);
        return (g == 0) ? 3 : 1;
    endfunction

    function automatic int n_ends(input int g);
        return (g == 0) ? 2 : 0;
    endfunction

    // Expected frame n of an update: START, then LEDs, then ENDs.
    function automatic int exp_type(input int g, input int n);
        if (n == 0) return 0;
        if (n <= n_leds(g)) return 1;
        return 2;
    endfunction

    function automatic int exp_rgb(input int g, input int n);
        if (n == 0 || n > n_leds(g)) return 0;
        return int'(mem[n-1]);
    endfunction

    // doled model (busy for 20 cycles per accepted start) and pixel buffer
    int dcnt [2];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int g = 0; g < 2; g++) begin
                dbusy[g] <= 1'b0;
                dcnt[g]  <= 0;
                pdata[g] <= 24'h0;
            end
        end else begin
            for (int g = 0; g < 2; g++) begin
                if (dbusy[g]) begin
                    if (dcnt[g] == 1) dbusy[g] <= 1'b0;
                    dcnt[g] <= dcnt[g] - 1;
                end else if (sst[g] && !nobusy[g]) begin
                    dbusy[g] <= 1'b1;
                    dcnt[g]  <= 20;
                end
                if (prd[g]) pdata[g] <= mem[paddr[g][1:0]];
            end
        end
    end

    // Per-cycle compare against the frame model
    int          fcnt  [2];
    int          rdcnt [2];
    int          dncnt [2];
    logic        pbusy [2];
    logic        pdb   [2];
    logic [1:0]  cur_t [2];
    logic [23:0] cur_c [2];
    logic [1:0]  ftype [2][8];
    logic [23:0] fcol  [2][8];

    initial begin
        for (int g = 0; g < 2; g++) begin
            fcnt[g] = 0; rdcnt[g] = 0; dncnt[g] = 0; pbusy[g] = 0; pdb[g] = 0;
        end
    end

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (!rst_n) begin
                pbusy[g] = 1'b0;
                pdb[g]   = 1'b0;
            end else begin
                if (fbusy[g] && !pbusy[g]) begin
                    fcnt[g]  = 0;
                    rdcnt[g] = 0;
                end
                if (dbusy[g] && !pdb[g]) begin
                    cur_t[g] = stype[g];
                    cur_c[g] = {sr[g], sg[g], sb[g]};
                    if (fcnt[g] < 8) begin
                        ftype[g][fcnt[g]] = stype[g];
                        fcol[g][fcnt[g]]  = cur_c[g];
                    end
                    check("frame_type", int'(stype[g]), exp_type(g, fcnt[g]));
                    if (exp_type(g, fcnt[g]) != 2)
                        check("frame_rgb", int'(cur_c[g]), exp_rgb(g, fcnt[g]));
                    fcnt[g]++;
                end else if (dbusy[g]) begin
                    check("hold_type", int'(stype[g]), int'(cur_t[g]));
                    check("hold_rgb", int'({sr[g], sg[g], sb[g]}), int'(cur_c[g]));
                end
                if (prd[g]) begin
                    check("pix_addr", int'(paddr[g]), rdcnt[g]);
                    rdcnt[g]++;
                end
                if (sst[g]) check("start_only_busy", int'(fbusy[g]), 1);
                if (fdone[g]) begin
                    check("frames_per_update", fcnt[g], 1 + n_leds(g) + n_ends(g));
                    check("pix_rd_cycles", rdcnt[g], n_leds(g));
                    dncnt[g]++;
                end
                pbusy[g] = fbusy[g];
                pdb[g]   = dbusy[g];
            end
        end
    end

    task automatic pulse_go(input int g);
        @(negedge clk) go[g] = 1'b1;
        @(negedge clk) go[g] = 1'b0;
    endtask

    task automatic wait_done(input int g, input string nm);
        int seen;
        seen = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (fdone[g]) begin
                seen = 1;
                break;
            end
        end
        check(nm, seen, 1);
    endtask

    task automatic check_all_zero(input int g, input string nm);
        check({nm, "_busy"}, int'(fbusy[g]), 0);
        check({nm, "_done"}, int'(fdone[g]), 0);
        check({nm, "_err"}, int'(ferr[g]), 0);
        check({nm, "_rd"}, int'(prd[g]), 0);
        check({nm, "_addr"}, int'(paddr[g]), 0);
        check({nm, "_type"}, int'(stype[g]), 0);
        check({nm, "_rgb"}, int'({sr[g], sg[g], sb[g]}), 0);
        check({nm, "_start"}, int'(sst[g]), 0);
    endtask

    int exp_types [6] = '{0, 1, 1, 1, 2, 2};
    int cnt;
    int seen;

    initial begin
        rst_n = 1'b0;
        go[0] = 1'b0; go[1] = 1'b0;
        nobusy[0] = 1'b0; nobusy[1] = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero(0, "rst0");
        check_all_zero(1, "rst1");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Normal update, literal expectations
        pulse_go(0);
        wait_done(0, "t1_done");
        check("t1_busy_with_done", int'(fbusy[0]), 0);
        repeat (5) @(negedge clk);
        check("t1_done_pulse", int'(fdone[0]), 0);
        for (int i = 0; i < 6; i++) check("t1_type_seq", int'(ftype[0][i]), exp_types[i]);
        check("t1_led0", int'(fcol[0][1]), 32'h112233);
        check("t1_led1", int'(fcol[0][2]), 32'h445566);
        check("t1_led2", int'(fcol[0][3]), 32'h778899);
        check("t1_done_count", dncnt[0], 1);

        // frame_go held through the update and the DONE cycle
        @(negedge clk) go[0] = 1'b1;
        seen = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (fdone[0]) begin
                seen = 1;
                break;
            end
        end
        check("t2_done", seen, 1);
        @(negedge clk) go[0] = 1'b0;
        repeat (30) @(negedge clk);
        check("t2_idle_after", int'(fbusy[0]), 0);
        check("t2_frames", fcnt[0], 6);
        check("t2_done_count", dncnt[0], 2);

        // Handshake timeout
        nobusy[0] = 1'b1;
        @(negedge clk) go[0] = 1'b1;
        cnt = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            go[0] = 1'b0;
            if (sst[0]) cnt++;
            if (ferr[0]) break;
        end
        check("t3_err", int'(ferr[0]), 1);
        check("t3_issue_cycles", cnt, 255);
        check("t3_busy", int'(fbusy[0]), 0);
        check("t3_start", int'(sst[0]), 0);
        repeat (5) @(negedge clk);
        check("t3_err_sticky", int'(ferr[0]), 1);
        check("t3_no_done", dncnt[0], 2);
        nobusy[0] = 1'b0;
        pulse_go(0);
        check("t3_err_cleared", int'(ferr[0]), 0);
        check("t3_busy_again", int'(fbusy[0]), 1);
        wait_done(0, "t3_done");
        repeat (3) @(negedge clk);
        check("t3_done_count", dncnt[0], 3);

        // Reset during the second LED frame
        pulse_go(0);
        seen = 0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            if (fcnt[0] == 3) begin
                seen = 1;
                break;
            end
        end
        check("t4_reach_led1", seen, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero(0, "t4_async");
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t4_no_done", dncnt[0], 3);
        pulse_go(0);
        wait_done(0, "t4_done");
        repeat (3) @(negedge clk);
        check("t4_frames", fcnt[0], 6);
        check("t4_first_start", int'(ftype[0][0]), 0);
        check("t4_done_count", dncnt[0], 4);

        // Single LED, no END frames
        pulse_go(1);
        wait_done(1, "t5_done");
        repeat (3) @(negedge clk);
        check("t5_frames", fcnt[1], 2);
        check("t5_type0", int'(ftype[1][0]), 0);
        check("t5_type1", int'(ftype[1][1]), 1);
        check("t5_led0", int'(fcol[1][1]), 32'h112233);
        check("t5_addr", int'(paddr[1]), 0);
        check("t5_done_count", dncnt[1], 1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/strip_seq.md
STRIP_SEQ -- requirements
Module: strip_seq

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 60: LED frames sent per strip update, legal range 1..1023.
REQ-002 SHALL have parameter END_FRAMES, default 4: count of END-type frames sent after the last LED.
REQ-003 SHALL have parameter AW, default 10: width of the pixel address.
REQ-004 SHALL have parameter HS_TIMEOUT, default 255: maximum cycles to wait for doled_busy to rise after a start request.
REQ-005 SHALL have port strip_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port strip_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port frame_go, input, 1 bit: request one full strip update.
REQ-008 SHALL have port frame_busy, output, 1 bit: high while an update is in progress.
REQ-009 SHALL have port frame_done, output, 1 bit: one-cycle pulse when an update completes normally.
REQ-010 SHALL have port frame_err, output, 1 bit: sticky handshake-timeout flag.
REQ-011 SHALL have port pix_rd, output, 1 bit: pixel buffer read strobe.
REQ-012 SHALL have port pix_addr, output, AW bits: pixel index being read.
REQ-013 SHALL have port pix_data, input, 24 bits: {red[23:16], green[15:8], blue[7:0]}, valid the cycle after pix_rd.
REQ-014 SHALL have port seq_type, output, 2 bits: frame type (0 START, 1 LED, 2 END); drives doled type_input.
REQ-015 SHALL have ports seq_blue, seq_green and seq_red, outputs, 8 bits each: colour bytes; drive the doled colour inputs.
REQ-016 SHALL have port seq_start, output, 1 bit: drives doled_start.
REQ-017 SHALL have port seq_busy, input, 1 bit: driven from doled_busy.

Function
REQ-018 SHALL implement states IDLE, ISSUE, WAIT_LOW, FETCH, LOAD, DONE.
REQ-019 IDLE, frame_go=1: SHALL set frame_busy=1, seq_type=0, colours=0, clear frame_err, and go to ISSUE; frame_go SHALL be ignored in every other state.
REQ-020 ISSUE: SHALL hold seq_start=1 until seq_busy=1 is sampled, then drive seq_start=0 and go to WAIT_LOW.
REQ-021 ISSUE: SHALL count cycles; if HS_TIMEOUT cycles elapse with seq_busy=0, it SHALL set frame_err=1, drop seq_start and frame_busy, and return to IDLE with no frame_done.
REQ-022 WAIT_LOW: SHALL wait for seq_busy=0, then advance according to the current phase.
REQ-023 After the START frame: SHALL clear led_idx to 0 and go to FETCH.
REQ-024 FETCH: SHALL drive pix_rd=1 and pix_addr=led_idx for exactly one cycle, then go to LOAD.
REQ-025 LOAD: SHALL capture pix_data into seq_red/seq_green/seq_blue, set seq_type=1, and go to ISSUE.
REQ-026 After an LED frame: if led_idx==NUM_LEDS-1, SHALL clear end_cnt, set seq_type=2, and go to ISSUE; otherwise SHALL increment led_idx and go to FETCH.
REQ-027 After an END frame: SHALL increment end_cnt; at end_cnt==END_FRAMES it SHALL go to DONE, otherwise back to ISSUE.
REQ-028 With END_FRAMES=0, SHALL go from the last LED frame straight to DONE.
REQ-029 DONE: SHALL pulse frame_done=1 for one cycle, drop frame_busy in the same cycle, and return to IDLE.
REQ-030 SHALL hold seq_type and the colour outputs stable from ISSUE entry until seq_busy falls.
REQ-031 SHALL keep seq_start=0 outside ISSUE.
REQ-032 SHALL never wrap led_idx; its width is AW bits and it stops at NUM_LEDS-1.
REQ-033 Frame count per update SHALL be exactly 1+NUM_LEDS+END_FRAMES.
REQ-034 frame_go asserted in the DONE cycle SHALL be ignored; a new update starts only from IDLE.

Reset
REQ-035 strip_rst_n=0 SHALL immediately force state=IDLE and all outputs to 0: frame_busy, frame_done, frame_err, pix_rd, pix_addr, seq_type, colours, seq_start, plus all counters.
REQ-036 Reset mid-update SHALL abandon the update with no frame_done; the next frame_go SHALL restart from the START frame.
REQ-037 Reset release SHALL take effect on the first rising strip_clk edge with strip_rst_n=1.

Verification
REQ-038 Bench SHALL run NUM_LEDS=3, END_FRAMES=2 against a doled model with 20-cycle busy and pixels 0x112233, 0x445566, 0x778899 -> doled sees types 0,1,1,1,2,2; LED bytes R/G/B=11/22/33, 44/55/66, 77/88/99; exactly one frame_done.
REQ-039 Bench SHALL run a model that never raises seq_busy, HS_TIMEOUT=255 -> frame_err=1 and frame_busy=0 after 255 ISSUE cycles; no frame_done; frame_err clears on the next frame_go.
REQ-040 Bench SHALL pulse frame_go repeatedly during an update -> no second START frame, frame count stays at 6.
REQ-041 Bench SHALL assert strip_rst_n=0 during the second LED frame -> all outputs 0 asynchronously; a new frame_go then produces a complete 6-frame sequence starting with a START frame.
REQ-042 Bench SHALL run NUM_LEDS=1, END_FRAMES=0 -> frame sequence 0,1 then frame_done; pix_addr only ever 0.
REQ-043 Bench SHALL assert, in every run, that seq_type and colours never change while seq_busy=1, and that pix_rd is high for exactly NUM_LEDS cycles per update.
